// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read ports, writeback,
// issue and flush from the pipeline side; read data, busy flags and pending count back.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) ();
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic                  we;
    logic [ADDR_W-1:0]     wa;
    logic [DATA_W-1:0]     wd;
    logic                  iss;
    logic [ADDR_W-1:0]     ia;
    logic                  flush;
    logic [ADDR_W:0]       pend_cnt;

    modport master (
        output ra, we, wa, wd, iss, ia, flush,
        input  rd, rbusy, pend_cnt
    );

    modport slave (
        input  ra, we, wa, wd, iss, ia, flush,
        output rd, rbusy, pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports, one write port, optional hardwired
// zero register, same-cycle write bypass and a per-register pending scoreboard.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]             mem [DEPTH];
    logic [DEPTH-1:0]              pend;
    logic [DEPTH-1:0]              pend_nxt;
    logic [ADDR_W:0]               cnt;
    logic [ADDR_W:0]               cnt_nxt;
    logic                          wr_eff;
    logic                          iss_eff;
    logic                          set_ev;
    logic                          clr_ev;
    logic [NRD-1:0][ADDR_W-1:0]    ra_a;
    logic [NRD-1:0][DATA_W-1:0]    rd_a;
    logic [NRD-1:0]                busy_a;

    assign wr_eff  = bus.we  && !(ZERO_REG && (bus.wa == '0));
    assign iss_eff = bus.iss && !(ZERO_REG && (bus.ia == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_eff) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // Flush, then writeback clear, then issue set: issue wins on a shared address.
    always_comb begin
        pend_nxt = pend;
        if (bus.flush) begin
            pend_nxt = '0;
        end
        if (bus.we) begin
            pend_nxt[bus.wa] = 1'b0;
        end
        if (iss_eff) begin
            pend_nxt[bus.ia] = 1'b1;
        end
        if (ZERO_REG) begin
            pend_nxt[0] = 1'b0;
        end
    end

    // Incremental count; a clear is cancelled when the same bit is re-issued this edge.
    always_comb begin
        set_ev = iss_eff && !pend[bus.ia];
        clr_ev = bus.we && pend[bus.wa] && !(iss_eff && (bus.ia == bus.wa));
        if (bus.flush) begin
            cnt_nxt = {{ADDR_W{1'b0}}, iss_eff};
        end else begin
            cnt_nxt = cnt + {{ADDR_W{1'b0}}, set_ev} - {{ADDR_W{1'b0}}, clr_ev};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign ra_a = bus.ra;

    // Array mux and bypass compare run in parallel; the compare only steers the final mux.
    always_comb begin
        rd_a   = '0;
        busy_a = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (reset && !(ZERO_REG && (ra_a[k] == '0))) begin
                if (BYPASS && wr_eff && (bus.wa == ra_a[k])) begin
                    rd_a[k] = bus.wd;
                end else begin
                    rd_a[k] = mem[ra_a[k]];
                end
                busy_a[k] = pend[ra_a[k]] && !(BYPASS && bus.we && (bus.wa == ra_a[k]));
            end
        end
    end

    assign bus.rd       = rd_a;
    assign bus.rbusy    = busy_a;
    assign bus.pend_cnt = cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance (32x32, 2 ports, zero reg, bypass) and a
// 64x64, 4-port instance without zero reg or bypass, both checked against an array model.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b0 ();
    reg_file_sb_if #(.DATA_W(64), .ADDR_W(6), .NRD(4)) b1 ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
        .clk(clk), .reset(rst), .bus(b0));
    reg_file_sb #(.DATA_W(64), .ADDR_W(6), .NRD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clk(clk), .reset(rst), .bus(b1));

    int n_chk  = 0;
    int n_fail = 0;

    // Model state and per-instance stimulus
    logic [63:0] mm [2][64];
    bit          mp [2][64];
    int          ra_v [2][4];
    bit          we_v [2];
    int          wa_v [2];
    logic [63:0] wd_v [2];
    bit          iss_v [2];
    int          ia_v [2];
    bit          fl_v [2];

    function automatic int depth(int i);        return (i == 0) ? 32 : 64; endfunction
    function automatic int nports(int i);       return (i == 0) ? 2 : 4;   endfunction
    function automatic bit zr(int i);           return (i == 0);           endfunction
    function automatic bit byp(int i);          return (i == 0);           endfunction
    function automatic logic [63:0] dmask(int i);
        return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction
    function automatic logic [63:0] sweep_val(int a);
        return {32'(a) ^ 32'hC0DE_0000, ~32'(a)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) ra_v[i][k] = 0;
            we_v[i] = 0; wa_v[i] = 0; wd_v[i] = '0;
            iss_v[i] = 0; ia_v[i] = 0; fl_v[i] = 0;
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 2; k++) b0.ra[k*5 +: 5] = 5'(ra_v[0][k]);
        for (int k = 0; k < 4; k++) b1.ra[k*6 +: 6] = 6'(ra_v[1][k]);
        b0.we = we_v[0]; b0.wa = 5'(wa_v[0]); b0.wd = wd_v[0][31:0];
        b0.iss = iss_v[0]; b0.ia = 5'(ia_v[0]); b0.flush = fl_v[0];
        b1.we = we_v[1]; b1.wa = 6'(wa_v[1]); b1.wd = wd_v[1];
        b1.iss = iss_v[1]; b1.ia = 6'(ia_v[1]); b1.flush = fl_v[1];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) begin
                mm[i][a] = '0;
                mp[i][a] = 0;
            end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (fl_v[i])
                for (int a = 0; a < 64; a++) mp[i][a] = 0;
            if (we_v[i]) begin
                mp[i][wa_v[i]] = 0;
                if (!(zr(i) && wa_v[i] == 0)) mm[i][wa_v[i]] = wd_v[i] & dmask(i);
            end
            if (iss_v[i] && !(zr(i) && ia_v[i] == 0)) mp[i][ia_v[i]] = 1;
        end
    endtask

    function automatic logic [63:0] exp_rd(int i, int a);
        if (!rst || (zr(i) && a == 0)) return '0;
        if (byp(i) && we_v[i] && wa_v[i] == a) return wd_v[i] & dmask(i);
        return mm[i][a];
    endfunction

    function automatic logic [63:0] exp_busy(int i, int a);
        if (!rst || (zr(i) && a == 0) || !mp[i][a]) return 0;
        if (we_v[i] && wa_v[i] == a) return byp(i) ? 0 : 1;
        return 1;
    endfunction

    function automatic logic [63:0] exp_cnt(int i);
        int s = 0;
        for (int a = 0; a < depth(i); a++) s += int'(mp[i][a]);
        return 64'(s);
    endfunction

    function automatic logic [63:0] act_rd(int i, int k);
        return (i == 0) ? 64'(b0.rd[k*32 +: 32]) : b1.rd[k*64 +: 64];
    endfunction
    function automatic logic [63:0] act_busy(int i, int k);
        return (i == 0) ? 64'(b0.rbusy[k]) : 64'(b1.rbusy[k]);
    endfunction
    function automatic logic [63:0] act_cnt(int i);
        return (i == 0) ? 64'(b0.pend_cnt) : 64'(b1.pend_cnt);
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < nports(i); k++) begin
                chk($sformatf("rd%0d_p%0d_r%0d", i, k, ra_v[i][k]), act_rd(i, k), exp_rd(i, ra_v[i][k]));
                chk($sformatf("rbusy%0d_p%0d_r%0d", i, k, ra_v[i][k]), act_busy(i, k), exp_busy(i, ra_v[i][k]));
            end
            chk($sformatf("pend_cnt%0d", i), act_cnt(i), exp_cnt(i));
        end
    endtask

    // One clock: drive, optionally assert reset mid-cycle, compare at negedge, advance model.
    task automatic cycle(input bit mid_rst);
        apply();
        if (mid_rst) begin
            #2;
            rst = 1'b0;
            model_clear();
        end
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    task automatic pre();
        apply();
        #1;
    endtask

    function automatic int pick(int i);
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, depth(i) - 1));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        apply();
        model_clear();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        cycle(0);
        chk("reset_cnt0", b0.pend_cnt, 0);
        chk("reset_rbusy0", b0.rbusy, 0);

        // Reset asserted mid-cycle after a write and an issue
        rst = 1'b1;
        idle();
        we_v[0] = 1; wa_v[0] = 5; wd_v[0] = 64'hDEAD_BEEF; iss_v[0] = 1; ia_v[0] = 6;
        we_v[1] = 1; wa_v[1] = 5; wd_v[1] = 64'hDEAD_BEEF;
        cycle(0);
        idle();
        ra_v[0][0] = 5; we_v[0] = 1; wa_v[0] = 5; wd_v[0] = 64'h0BAD_F00D;
        pre();
        chk("pre_rst_bypass", b0.rd[31:0], 64'h0BAD_F00D);
        chk("pre_rst_cnt", b0.pend_cnt, 1);
        cycle(1);
        chk("in_rst_rd", b0.rd[31:0], 0);
        chk("in_rst_cnt", b0.pend_cnt, 0);
        cycle(0);
        rst = 1'b1;
        idle();
        ra_v[0][0] = 5; ra_v[1][0] = 5;
        pre();
        chk("r5_after_rst0", b0.rd[31:0], 0);
        chk("r5_after_rst1", b1.rd[63:0], 0);
        cycle(0);

        // Zero register
        idle(); we_v[0] = 1; wa_v[0] = 0; wd_v[0] = 64'h1234; ra_v[0][0] = 0;
        pre(); chk("zero_rd_same", b0.rd[31:0], 0); cycle(0);
        idle(); iss_v[0] = 1; ia_v[0] = 0;
        pre(); chk("zero_rd_next", b0.rd[31:0], 0); cycle(0);
        idle();
        pre(); chk("zero_iss_cnt", b0.pend_cnt, 0); chk("zero_rbusy", b0.rbusy[0], 0); cycle(0);

        // Bypass vs. no bypass
        idle();
        we_v[0] = 1; wa_v[0] = 7; wd_v[0] = 64'hA5A5_A5A5; ra_v[0][0] = 7;
        we_v[1] = 1; wa_v[1] = 7; wd_v[1] = 64'h1111_2222_3333_4444;
        pre(); chk("byp_rd", b0.rd[31:0], 64'hA5A5_A5A5); chk("byp_rbusy", b0.rbusy[0], 0); cycle(0);
        idle(); we_v[1] = 1; wa_v[1] = 7; wd_v[1] = 64'h5555_6666_7777_8888; ra_v[1][0] = 7;
        pre(); chk("nobyp_old", b1.rd[63:0], 64'h1111_2222_3333_4444); cycle(0);
        idle(); ra_v[1][0] = 7;
        pre(); chk("nobyp_new", b1.rd[63:0], 64'h5555_6666_7777_8888); cycle(0);
        idle(); iss_v[1] = 1; ia_v[1] = 8; cycle(0);
        idle(); we_v[1] = 1; wa_v[1] = 8; wd_v[1] = 64'h99; ra_v[1][1] = 8;
        pre(); chk("nobyp_busy_same", b1.rbusy[1], 1); cycle(0);
        idle(); ra_v[1][1] = 8;
        pre(); chk("nobyp_busy_next", b1.rbusy[1], 0); cycle(0);

        // Scoreboard
        idle(); iss_v[0] = 1; ia_v[0] = 3; cycle(0);
        idle(); ra_v[0][1] = 3;
        pre(); chk("sb_iss_busy", b0.rbusy[1], 1); chk("sb_iss_cnt", b0.pend_cnt, 1); cycle(0);
        idle(); iss_v[0] = 1; ia_v[0] = 3; we_v[0] = 1; wa_v[0] = 3; wd_v[0] = 64'h77; cycle(0);
        idle(); ra_v[0][1] = 3;
        pre(); chk("sb_both_busy", b0.rbusy[1], 1); chk("sb_both_cnt", b0.pend_cnt, 1); cycle(0);
        idle(); we_v[0] = 1; wa_v[0] = 3; wd_v[0] = 64'h78; cycle(0);
        idle(); ra_v[0][1] = 3;
        pre(); chk("sb_wb_busy", b0.rbusy[1], 0); chk("sb_wb_cnt", b0.pend_cnt, 0); cycle(0);

        // Flush with concurrent issue
        for (int n = 0; n < 3; n++) begin
            idle(); iss_v[0] = 1; ia_v[0] = (n == 2) ? 4 : n + 1; cycle(0);
        end
        idle(); fl_v[0] = 1; iss_v[0] = 1; ia_v[0] = 9;
        pre(); chk("flush_pre_cnt", b0.pend_cnt, 3); cycle(0);
        idle(); ra_v[0][0] = 9; ra_v[0][1] = 1;
        pre();
        chk("flush_cnt", b0.pend_cnt, 1);
        chk("flush_r9_busy", b0.rbusy[0], 1);
        chk("flush_r1_clear", b0.rbusy[1], 0);
        cycle(0);

        // Wide instance: fill all 64 registers, read back on four independent ports
        for (int a = 0; a < 64; a++) begin
            idle(); we_v[1] = 1; wa_v[1] = a; wd_v[1] = sweep_val(a); cycle(0);
        end
        for (int a = 0; a < 64; a += 4) begin
            idle();
            for (int k = 0; k < 4; k++) ra_v[1][k] = (a + 17 * k) % 64;
            pre();
            for (int k = 0; k < 4; k++)
                chk($sformatf("sweep_p%0d_r%0d", k, ra_v[1][k]), b1.rd[k*64 +: 64], sweep_val(ra_v[1][k]));
            cycle(0);
        end

        // Randomized traffic with collisions, flushes and occasional mid-cycle reset
        for (int n = 0; n < 3000; n++) begin
            if (!rst) rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 4; k++) ra_v[i][k] = pick(i);
                we_v[i]  = ($urandom_range(0, 1) == 1);
                wa_v[i]  = pick(i);
                wd_v[i]  = {$urandom, $urandom} & dmask(i);
                iss_v[i] = ($urandom_range(0, 9) < 4);
                ia_v[i]  = pick(i);
                fl_v[i]  = ($urandom_range(0, 31) == 0);
            end
            cycle($urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the pipeline's 32x32 register file. It provides NRD combinational read ports and one write port, with three additions:
- a configurable hardwired zero register;
- same-cycle write-to-read bypass;
- a per-register pending (scoreboard) bit, plus an outstanding-write counter.

It sits in decode/writeback: decode reads operands and issues destinations, and writeback retires them.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears array, pending bits, counter
- ra  in  NRD*ADDR_W  read addresses; port k = ra[k*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data; port k = rd[k*DATA_W +: DATA_W]
- rbusy  out  NRD  port k's register is pending (write outstanding)
- we  in  1  write enable (writeback)
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- iss  in  1  issue: mark register ia pending
- ia  in  ADDR_W  issue address
- flush  in  1  clear all pending bits (pipeline squash)
- pend_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Array: 2**ADDR_W x DATA_W.
  - On a rising edge with we=1, mem[wa] <= wd, except wa=0 with ZERO_REG=1, which is dropped.
- Read port k (combinational):
  - reset=0: rd=0.
  - ZERO_REG=1 and ra_k=0: rd=0.
  - BYPASS=1, we=1, wa=ra_k, and the write is not dropped: rd=wd.
  - Otherwise: rd=mem[ra_k].
- Pending bit p[i]; next value per edge, in priority order:
  1. flush=1: all bits cleared.
  2. we=1: p[wa] cleared.
  3. iss=1: p[ia] set.
  - Issue is applied after flush and write, so issue wins both on the same address and over flush in the same cycle.
  - ZERO_REG=1: p[0] is held at 0 and issues to 0 are ignored.
- rbusy_k = p[ra_k], except when a same-cycle write to ra_k clears it; then rbusy_k = 0 if BYPASS=1, else 1.
  - ZERO_REG=1 and ra_k=0: rbusy_k = 0.
- pend_cnt: registered population count of p, maintained incrementally.
  - +1 on an effective set of a clear bit.
  - -1 on an effective clear of a set bit.
  - Net 0 when both events hit the same bit or cancel.
  - Reloaded to the population count of the post-flush state on flush (0, or 1 if a legal issue accompanies it).
  - Never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG=1).
- Redundant events: a write to a non-pending register and an issue to an already-pending register leave p and pend_cnt unchanged.
- No handshake back-pressure. The caller must not issue when rbusy is needed-clear; the block does not stall.

## Timing
- Reset:
  - Assertion is immediate (asynchronous): rd=0, rbusy=0, pend_cnt=0, array zeroed.
  - Deassertion is synchronised by the caller. The first edge after release may write.
- Write latency: data is visible via bypass in the same cycle (BYPASS=1), or from the array one cycle after the edge (BYPASS=0).
- Issue latency: rbusy rises the cycle after the iss edge. pend_cnt updates on the same edge.
- Reset asserted mid-cycle overrides any concurrent we/iss/flush. Nothing from that cycle is retained.
- Critical path: ra decode -> array mux -> bypass compare mux -> rd. The bypass compare is in parallel with the mux.

## Test plan
- Reset: hold reset=0 after writes of 0xDEADBEEF to r5 -> rd=0, pend_cnt=0, and r5 reads 0 after release.
- Zero register (ZERO_REG=1): we=1, wa=0, wd=0x1234 -> ra=0 reads 0. iss to 0 -> pend_cnt stays 0.
- Bypass (BYPASS=1): we=1, wa=7, wd=0xA5A5A5A5 with ra0=7 in the same cycle -> rd0=0xA5A5A5A5, rbusy0=0. With BYPASS=0 -> rd0 returns the old value, and the new value appears the next cycle.
- Scoreboard:
  - iss r3 -> next cycle rbusy=1, pend_cnt=1.
  - iss r3 and we r3 in the same cycle -> r3 stays pending, pend_cnt=1.
  - we r3 -> rbusy=0, pend_cnt=0.
- Flush: pend r1, r2, r4 (pend_cnt=3), then flush=1 with iss r9 -> next cycle pend_cnt=1, only r9 busy.
- Parameter sweep: NRD=4, ADDR_W=6, DATA_W=64 -> write/read all 64 registers with address-derived data, and all four ports read independently.
